copro_result_fifo: RTL
======================

// Module: copro_result_fifo
// PURPOSE
//   Result buffer directly downstream of the CV-X-IF example coprocessor ALU. Captures every
//   registered ALU result (result, hartid, id, rd, we) in program order and presents it to the
//   core's result interface over a valid/ready handshake. The ALU has no backpressure, so this
//   block also drives issue_ready_o back to the issue stage, reserving SKID slots for in-flight ops.
// PARAMETERS
//   XLEN      32  result data width
//   HARTID_W  1   hart id width
//   ID_W      3   instruction id width
//   DEPTH     4   entries, >= 2, not required to be a power of two
//   SKID      1   slots reserved for ops already issued to the ALU, 1 <= SKID < DEPTH
// PORTS
//   clk_i            in   1                    clock
//   rst_ni           in   1                    reset, asynchronous, active-low
//   flush_i          in   1                    synchronous clear of all buffered entries
//   alu_valid_i      in   1                    ALU result valid (one push per cycle)
//   alu_result_i     in   XLEN                 ALU result value
//   alu_hartid_i     in   HARTID_W             hart id of the result
//   alu_id_i         in   ID_W                 instruction id of the result
//   alu_rd_i         in   5                    destination register
//   alu_we_i         in   1                    register write enable
//   issue_ready_o    out  1                    issue stage may send a new op to the ALU
//   result_valid_o   out  1                    head entry valid toward the core
//   result_ready_i   in   1                    core accepts head entry
//   result_data_o    out  XLEN                 head result
//   result_hartid_o  out  HARTID_W             head hart id
//   result_id_o      out  ID_W                 head instruction id
//   result_rd_o      out  5                    head rd
//   result_we_o      out  1                    head we
//   count_o          out  $clog2(DEPTH+1)      occupied entries
//   overflow_o       out  1                    sticky: a push was dropped
// BEHAVIOUR
//   - Reset (async, rst_ni=0): pointers and count = 0, overflow_o = 0, result_valid_o = 0,
//     issue_ready_o = 1, all result_* outputs = 0. Storage array is not reset.
//   - push = alu_valid_i & ~flush_i; pop = result_valid_o & result_ready_i & ~flush_i.
//   - result_valid_o = (count != 0). No fall-through: a push is visible at the head one cycle later.
//   - result_* outputs show the head entry when result_valid_o=1, and are forced to 0 when empty.
//   - Push accepted when count < DEPTH, or when count == DEPTH and pop is asserted the same cycle.
//   - Push while full without pop: entry dropped, count unchanged, overflow_o set until reset
//     (flush does not clear it).
//   - Simultaneous push and pop: count unchanged; both pointers advance.
//   - Pointers wrap from DEPTH-1 to 0 (explicit compare; DEPTH is not required to be a power of 2).
//   - issue_ready_o = (count + push - pop) < (DEPTH - SKID), computed from next-state count and
//     registered; it reflects the occupancy after the current edge.
//   - flush_i: at the next edge count and pointers = 0, and result_valid_o = 0 in the following
//     cycle. Any push or pop in the flush cycle is ignored.
//   - Result ordering is strictly FIFO. The ALU's we=0 results (e.g. opcode 0001) are buffered and
//     returned like any other result.
//   - Reset asserted mid-transfer: contents are discarded immediately; no partial handshake survives.
//   - count_o is registered and never exceeds DEPTH.
// TESTING
//   1. Single push {result=0x5,id=2,rd=7,we=1}, result_ready_i=1 -> result_valid_o=1 exactly one
//      cycle after the push, fields match, then empty; count_o returns 0.
//   2. DEPTH=4, SKID=1, ready=0, 3 pushes -> issue_ready_o=0 after the 3rd. A 4th in-flight push is
//      accepted, count_o=4, overflow_o=0.
//   3. Full, ready=0, 5th push -> dropped, overflow_o=1 sticky. The head is still entry 1.
//      A flush leaves overflow_o=1.
//   4. Full with simultaneous push and pop -> count_o stays 4. Drain yields ids in order
//      2,3,4,5 across the pointer wrap.
//   5. 3 entries, flush_i with alu_valid_i=1 in the same cycle -> count_o=0 next cycle, no output.
//   6. rst_ni pulsed low asynchronously with 2 entries buffered -> all outputs at reset values
//      before the next clk_i edge.

Source files
------------

// File: rtl/copro_result_fifo.sv
// Result buffer between the coprocessor ALU and the core result interface.
// Holds ALU results in program order and throttles issue so in-flight ops always fit.
module copro_result_fifo #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned HARTID_W = 1,
  parameter int unsigned ID_W     = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SKID     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         alu_valid_i,
  input  logic [XLEN-1:0]              alu_result_i,
  input  logic [HARTID_W-1:0]          alu_hartid_i,
  input  logic [ID_W-1:0]              alu_id_i,
  input  logic [4:0]                   alu_rd_i,
  input  logic                         alu_we_i,
  output logic                         issue_ready_o,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [XLEN-1:0]              result_data_o,
  output logic [HARTID_W-1:0]          result_hartid_o,
  output logic [ID_W-1:0]              result_id_o,
  output logic [4:0]                   result_rd_o,
  output logic                         result_we_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]     data;
    logic [HARTID_W-1:0] hartid;
    logic [ID_W-1:0]     id;
    logic [4:0]          rd;
    logic                we;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        entry_in;
  entry_t        head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          issue_ready_q, issue_ready_d;
  logic          valid, full, push, pop, push_acc;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    valid    = (count_q != '0);
    full     = (count_q == CW'(DEPTH));
    push     = alu_valid_i & ~flush_i;
    pop      = valid & result_ready_i & ~flush_i;
    // A full buffer can still take a push when the head leaves in the same cycle.
    push_acc = push & (~full | pop);

    entry_in = '{data: alu_result_i, hartid: alu_hartid_i, id: alu_id_i,
                 rd: alu_rd_i, we: alu_we_i};

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)      rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_acc, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Registered from next-state occupancy so it already accounts for this edge.
    issue_ready_d = (count_d < CW'(DEPTH - SKID));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      issue_ready_q <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      issue_ready_q <= issue_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= entry_in;
  end

  always_comb begin
    head            = valid ? mem_q[rd_ptr_q] : '0;
    result_valid_o  = valid;
    result_data_o   = head.data;
    result_hartid_o = head.hartid;
    result_id_o     = head.id;
    result_rd_o     = head.rd;
    result_we_o     = head.we;
    count_o         = count_q;
    overflow_o      = overflow_q;
    issue_ready_o   = issue_ready_q;
  end

endmodule
